// File: rtl/nn_layer_mac.sv
// Time-multiplexed fully-connected layer with one shared signed MAC.
// Computes out[o] = sat(sum_i in[i]*w[o][i] >>> FRAC_W), with optional ReLU.
// The weights live in an internal register file that is loaded through a write port.
module nn_layer_mac #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    localparam int unsigned NW    = N_IN * N_OUT,
    localparam int unsigned AW    = (NW > 1) ? $clog2(NW) : 1,
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N_IN) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      w_we_i,
    input  logic [AW-1:0]             w_addr_i,
    input  logic [DATA_W-1:0]         w_data_i,
    output logic                      w_ready_o,
    input  logic                      relu_en_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [N_IN*DATA_W-1:0]    in_vec_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [N_OUT*DATA_W-1:0]   out_vec_o,
    output logic                      busy_o
);
    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             i_q, i_d;
    logic [OW-1:0]             o_q, o_d;
    logic [AW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      relu_q;
    logic signed [DATA_W-1:0]  in_q  [N_IN];
    logic signed [DATA_W-1:0]  w_q   [NW];
    logic signed [DATA_W-1:0]  out_q [N_OUT];
    logic signed [DATA_W-1:0]  out_d [N_OUT];

    logic                      accept;
    logic                      i_last, o_last;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [DATA_W-1:0]  res;

    assign in_ready_o  = (state_q == StIdle);
    assign w_ready_o   = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign accept      = in_valid_i && in_ready_o;
    assign i_last      = (i_q == IW'(N_IN - 1));
    assign o_last      = (o_q == OW'(N_OUT - 1));

    // Datapath: one product per cycle, then round-down, saturation and ReLU on the last term.
    always_comb begin
        prod    = in_q[i_q] * w_q[k_q];
        sum     = (i_q == '0) ? ACC_W'(prod) : acc_q + ACC_W'(prod);
        shifted = sum >>> FRAC_W;
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DATA_W-1:0];
        end else begin
            res = shifted[DATA_W-1:0];
        end
        if (relu_q && res[DATA_W-1]) begin
            res = '0;
        end
    end

    // Next-state logic for the FSM, the counters, the accumulator and the result registers.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        o_d     = o_q;
        k_d     = k_q;
        acc_d   = acc_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StMac;
                    i_d     = '0;
                    o_d     = '0;
                    k_d     = '0;
                end
            end
            StMac: begin
                acc_d = sum;
                k_d   = k_q + AW'(1);
                if (i_last) begin
                    out_d[o_q] = res;
                    i_d        = '0;
                    if (o_last) begin
                        o_d     = '0;
                        state_d = StDone;
                    end else begin
                        o_d = o_q + OW'(1);
                    end
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter, accumulator and result registers; inputs and relu_en are captured on accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            i_q     <= '0;
            o_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            relu_q  <= 1'b0;
            for (int n = 0; n < N_IN; n++) in_q[n] <= '0;
            for (int n = 0; n < N_OUT; n++) out_q[n] <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            o_q     <= o_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            if (accept) begin
                relu_q <= relu_en_i;
                for (int n = 0; n < N_IN; n++) in_q[n] <= in_vec_i[n*DATA_W +: DATA_W];
            end
        end
    end

    // Weight register file; writes are accepted only in idle, and out-of-range addresses are dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NW; n++) w_q[n] <= '0;
        end else if (w_we_i && w_ready_o && (32'(w_addr_i) < NW)) begin
            w_q[w_addr_i] <= w_data_i;
        end
    end

    // Flatten the result registers onto the output bus.
    always_comb begin
        out_vec_o = '0;
        for (int n = 0; n < N_OUT; n++) out_vec_o[n*DATA_W +: DATA_W] = out_q[n];
    end
endmodule
